ev_lat_stats: RTL and testbench
===============================

Name: ev_lat_stats

Overview:
- Downstream consumer of the event timer's result stream; takes (id, delta) results and accumulates per-ID latency statistics: sample count, sum, min, max.
- Software and debug logic read them through a query/response port, with optional clear-on-read.
- Feeds the UDP status/telemetry path.
- Table is a flat per-ID array cleared by an init sweep after reset (RAM-friendly).

Parameters:
- ID_W, 3, id width; table depth is 2**ID_W entries.
- TS_W, 8, delta width; matches the timer's timestamp width.
- CNT_W, 8, per-ID sample count width (saturating).
- SUM_W, 16, per-ID delta sum width (saturating); SUM_W >= TS_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  result valid from the timer output
- in_ready  out  1  result accepted
- in_id  in  ID_W  result id
- in_delta  in  TS_W  end_ts - start_ts (already modulo 2**TS_W)
- qry_valid  in  1  query request
- qry_ready  out  1  query accepted
- qry_id  in  ID_W  entry to read
- qry_clear  in  1  clear the entry on the same edge it is read
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  ID_W  echoed query id
- rsp_count  out  CNT_W  samples
- rsp_sum  out  SUM_W  sum of deltas
- rsp_min  out  TS_W  minimum delta; all-ones when count = 0
- rsp_max  out  TS_W  maximum delta; 0 when count = 0
- sat_flag  out  1  sticky: any count or sum saturated since reset

Behaviour:
- Reset and init state machine:
  - rst has priority over everything, including mid-operation; it forces state INIT, init pointer 0, rsp_valid = 0, sat_flag = 0.
  - All rsp_* data outputs reset to 0; in_ready = qry_ready = 0.
  - INIT writes the empty entry (count 0, sum 0, min all-ones, max 0) to entry[ptr], one per cycle.
  - INIT lasts exactly 2**ID_W cycles after rst deasserts, then moves to RUN. No other transitions.
- Input handshake:
  - in_ready = (state == RUN).
  - A transfer occurs when in_valid && in_ready at a posedge; the entry updates on that same edge:
    - count = sat(count + 1)
    - sum = sat(sum + delta), with delta zero-extended
    - min = min(min, delta); max = max(max, delta)
  - Saturation clamps to all-ones and sets sat_flag; sat_flag stays set until rst.
- Query handshake:
  - qry_ready = RUN && (!rsp_valid || rsp_ready) && !(in_valid && in_id == qry_id).
  - On a query transfer:
    - The entry is snapshotted into the rsp_* registers.
    - rsp_valid rises the next cycle (1-cycle latency).
    - If qry_clear, the entry is reset to empty on the same edge.
  - rsp_valid and rsp_* stay stable until rsp_valid && rsp_ready.
  - A query accepted in the same cycle that the old response is consumed is allowed (back-to-back, 1 response per cycle).
- Same-ID collision: an input update to id X and a query of id X in the same cycle means the update wins. The query stalls (qry_ready = 0) and succeeds next cycle, so its snapshot includes the update.
- Different-ID update and query in the same cycle: both proceed.
- Counts and sums never wrap; min and max are unsigned compares.

Decomposition:
- Shared package ev_pkg holds:
  - ID_W/TS_W defaults
  - stat_entry_t (count, sum, min, max) and the STAT_EMPTY constant
  - the state enum {INIT, RUN}
- One sub-module, ev_stat_update: combinational old entry + delta -> new entry + saturation flag.
  - Reused for the clear path by selecting STAT_EMPTY.
- The table and FSM stay in ev_lat_stats.

Test Plan (ID_W=3, TS_W=8, CNT_W=8, SUM_W=16):
- Reset release -> in_ready and qry_ready low for exactly 8 cycles after rst deasserts, high on the 9th. A query of any id -> count=0, sum=0, min=255, max=0.
- Push id3 deltas 5, 20, 7, then query id3 -> rsp_count=3, sum=32, min=5, max=20, rsp_id=3, rsp_valid one cycle after the query handshake.
- Query id3 with qry_clear=1 -> returns 3/32/5/20. A second query id3 -> 0/0/255/0. id2 (untouched) is unaffected.
- Same cycle: in_valid id2 delta=9 and qry_valid id2 -> in accepted, qry_ready=0 that cycle. The query is accepted next cycle and returns count=1, min=max=9.
- 300 pushes of delta=255 to id1 -> count=255, sum=65535, sat_flag=1 (sticky). rst mid-sequence -> sat_flag=0, INIT re-runs, id1 reads empty.
- Hold rsp_ready=0 for 5 cycles after a query -> rsp_* stable, qry_ready=0. Release -> handshake, and a back-to-back query the same cycle is accepted.

Source files
------------

// File: rtl/ev_pkg.sv
// Shared types and default widths for the per-ID latency statistics block.
package ev_pkg;

  localparam int DEF_ID_W  = 3;
  localparam int DEF_TS_W  = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_SUM_W = 16;

  // One table entry. Field widths follow the defaults above; the top-level
  // width parameters are expected to match them.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_SUM_W-1:0] sum;
    logic [DEF_TS_W-1:0]  dmin;
    logic [DEF_TS_W-1:0]  dmax;
  } stat_entry_t;

  // Empty entry: min starts at all-ones so the first sample always replaces it.
  localparam stat_entry_t STAT_EMPTY = '{
    count: {DEF_CNT_W{1'b0}},
    sum:   {DEF_SUM_W{1'b0}},
    dmin:  {DEF_TS_W{1'b1}},
    dmax:  {DEF_TS_W{1'b0}}
  };

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ev_stat_update.sv
// Folds one delta sample into a statistics entry with saturating count/sum.
module ev_stat_update
  import ev_pkg::*;
(
  input  stat_entry_t             old_i,
  input  logic [DEF_TS_W-1:0]     delta_i,
  output stat_entry_t             new_o,
  output logic                    sat_o
);

  logic [DEF_CNT_W:0] cnt_ext;
  logic [DEF_SUM_W:0] sum_ext;

  // Widened adds expose the carry so overflow clamps instead of wrapping.
  always_comb begin
    cnt_ext = {1'b0, old_i.count} + {{DEF_CNT_W{1'b0}}, 1'b1};
    sum_ext = {1'b0, old_i.sum} + {{(DEF_SUM_W + 1 - DEF_TS_W){1'b0}}, delta_i};
    new_o   = old_i;
    sat_o   = 1'b0;
    if (cnt_ext[DEF_CNT_W]) begin
      new_o.count = {DEF_CNT_W{1'b1}};
      sat_o       = 1'b1;
    end else begin
      new_o.count = cnt_ext[DEF_CNT_W-1:0];
    end
    if (sum_ext[DEF_SUM_W]) begin
      new_o.sum = {DEF_SUM_W{1'b1}};
      sat_o     = 1'b1;
    end else begin
      new_o.sum = sum_ext[DEF_SUM_W-1:0];
    end
    if (delta_i < old_i.dmin) begin
      new_o.dmin = delta_i;
    end else begin
      new_o.dmin = old_i.dmin;
    end
    if (delta_i > old_i.dmax) begin
      new_o.dmax = delta_i;
    end else begin
      new_o.dmax = old_i.dmax;
    end
  end

endmodule

// File: rtl/ev_lat_stats.sv
// Per-ID latency statistics table fed by the event timer result stream,
// read back through a query/response port with optional clear-on-read.
module ev_lat_stats
  import ev_pkg::*;
#(
  parameter int ID_W  = DEF_ID_W,
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_id,
  input  logic [TS_W-1:0]  in_delta,
  input  logic             qry_valid,
  output logic             qry_ready,
  input  logic [ID_W-1:0]  qry_id,
  input  logic             qry_clear,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [CNT_W-1:0] rsp_count,
  output logic [SUM_W-1:0] rsp_sum,
  output logic [TS_W-1:0]  rsp_min,
  output logic [TS_W-1:0]  rsp_max,
  output logic             sat_flag
);

  localparam int DEPTH = 2 ** ID_W;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   init_ptr_q, init_ptr_d;
  stat_entry_t       table_q [DEPTH];

  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  stat_entry_t       rsp_ent_q, rsp_ent_d;
  logic              sat_q, sat_d;

  logic              run;
  logic              in_fire;
  logic              qry_fire;
  stat_entry_t       upd_entry;
  logic              upd_sat;

  assign run      = (state_q == ST_RUN);
  assign in_ready = run;
  assign in_fire  = in_valid && run;
  // A same-ID input update takes precedence; the query waits one cycle so
  // its snapshot already contains the new sample.
  assign qry_ready = run && (!rsp_valid_q || rsp_ready) &&
                     !(in_valid && (in_id == qry_id));
  assign qry_fire  = qry_valid && qry_ready;

  ev_stat_update u_upd (
    .old_i   (table_q[in_id]),
    .delta_i (in_delta),
    .new_o   (upd_entry),
    .sat_o   (upd_sat)
  );

  // Init sweep: walk the table once, then stay in RUN until the next reset.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + ID_W'(1);
        if (init_ptr_q == {ID_W{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Response holding register and sticky saturation flag next state.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_ent_d   = rsp_ent_q;
    sat_d       = sat_q | (in_fire & upd_sat);
    if (qry_fire) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = qry_id;
      rsp_ent_d   = table_q[qry_id];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= {ID_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_ent_q   <= '{count: {DEF_CNT_W{1'b0}}, sum: {DEF_SUM_W{1'b0}},
                       dmin: {DEF_TS_W{1'b0}}, dmax: {DEF_TS_W{1'b0}}};
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ent_q   <= rsp_ent_d;
      sat_q       <= sat_d;
    end
  end

  // Table writes: init sweep, sample update and clear-on-read. Update and
  // clear never hit the same entry because qry_ready excludes that case.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        table_q[init_ptr_q] <= STAT_EMPTY;
      end else begin
        if (in_fire) begin
          table_q[in_id] <= upd_entry;
        end
        if (qry_fire && qry_clear) begin
          table_q[qry_id] <= STAT_EMPTY;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_count = rsp_ent_q.count;
  assign rsp_sum   = rsp_ent_q.sum;
  assign rsp_min   = rsp_ent_q.dmin;
  assign rsp_max   = rsp_ent_q.dmax;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_ev_lat_stats.sv
// Scoreboard bench for ev_lat_stats: queries push expected responses, a
// monitor pops and compares them whenever a response handshake occurs.
module tb_ev_lat_stats;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_id;
  logic [7:0] in_delta;
  logic       qry_valid;
  logic       qry_ready;
  logic [2:0] qry_id;
  logic       qry_clear;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_id;
  logic [7:0] rsp_count;
  logic [15:0] rsp_sum;
  logic [7:0] rsp_min;
  logic [7:0] rsp_max;
  logic       sat_flag;

  typedef struct {
    int id;
    int cnt;
    int sum;
    int mn;
    int mx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ev_lat_stats dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_id     (in_id),
    .in_delta  (in_delta),
    .qry_valid (qry_valid),
    .qry_ready (qry_ready),
    .qry_id    (qry_id),
    .qry_clear (qry_clear),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_sum   (rsp_sum),
    .rsp_min   (rsp_min),
    .rsp_max   (rsp_max),
    .sat_flag  (sat_flag)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input int c, input int s, input int mn, input int mx);
    exp_t e;
    e.id = id; e.cnt = c; e.sum = s; e.mn = mn; e.mx = mx;
    return e;
  endfunction

  // Monitor: every accepted response is checked against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d with no expected response", rsp_id);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id",    int'(rsp_id),    e.id);
        chk("rsp_count", int'(rsp_count), e.cnt);
        chk("rsp_sum",   int'(rsp_sum),   e.sum);
        chk("rsp_min",   int'(rsp_min),   e.mn);
        chk("rsp_max",   int'(rsp_max),   e.mx);
      end
    end
  end

  task automatic push(input int id, input int d);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1; in_id = 3'(id); in_delta = 8'(d);
    k = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) chk("in_ready_timeout", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic query(input int id, input bit clr, input exp_t e);
    int k;
    exp_q.push_back(e);
    @(posedge clk); #1;
    qry_valid = 1'b1; qry_id = 3'(id); qry_clear = clr;
    k = 0;
    @(negedge clk);
    while (qry_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (qry_ready !== 1'b1) chk("qry_ready_timeout", int'(qry_ready), 1);
    @(posedge clk); #1;
    qry_valid = 1'b0; qry_clear = 1'b0;
    chk("rsp_latency", int'(rsp_valid), 1);
  endtask

  // Release reset and check the readies stay low for exactly the init sweep.
  task automatic init_check();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || qry_ready !== 1'b0) begin
        chk("init_in_ready", int'(in_ready), 0);
        chk("init_qry_ready", int'(qry_ready), 0);
      end
    end
    @(negedge clk);
    chk("run_in_ready", int'(in_ready), 1);
    chk("run_qry_ready", int'(qry_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_id = 3'd0; in_delta = 8'd0;
    qry_valid = 1'b0; qry_id = 3'd0; qry_clear = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_qry_ready", int'(qry_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_sat_flag",  int'(sat_flag),  0);
    chk("rst_rsp_count", int'(rsp_count), 0);
    chk("rst_rsp_min",   int'(rsp_min),   0);
    init_check();

    // Freshly initialised entries read empty.
    query(5, 1'b0, mk(5, 0, 0, 255, 0));
    query(0, 1'b0, mk(0, 0, 0, 255, 0));

    // Accumulate on id3, then read, clear-on-read, re-read.
    push(3, 5); push(3, 20); push(3, 7);
    query(3, 1'b0, mk(3, 3, 32, 5, 20));
    query(3, 1'b1, mk(3, 3, 32, 5, 20));
    query(3, 1'b0, mk(3, 0, 0, 255, 0));
    query(2, 1'b0, mk(2, 0, 0, 255, 0));

    // Same-ID collision: update wins, query follows one cycle later.
    @(posedge clk); #1;
    in_valid = 1'b1; in_id = 3'd2; in_delta = 8'd9;
    qry_valid = 1'b1; qry_id = 3'd2; qry_clear = 1'b0;
    exp_q.push_back(mk(2, 1, 9, 9, 9));
    @(negedge clk);
    chk("coll_qry_ready", int'(qry_ready), 0);
    chk("coll_in_ready",  int'(in_ready),  1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("coll_qry_retry", int'(qry_ready), 1);
    @(posedge clk); #1;
    qry_valid = 1'b0;

    // Different-ID update and query proceed together.
    @(posedge clk); #1;
    in_valid = 1'b1; in_id = 3'd4; in_delta = 8'd3;
    qry_valid = 1'b1; qry_id = 3'd2;
    exp_q.push_back(mk(2, 1, 9, 9, 9));
    @(negedge clk);
    chk("diff_qry_ready", int'(qry_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; qry_valid = 1'b0;
    query(4, 1'b0, mk(4, 1, 3, 3, 3));
    @(negedge clk);
    @(posedge clk); #1;

    // Backpressure: response held, next query blocked, then back-to-back.
    rsp_ready = 1'b0;
    query(2, 1'b0, mk(2, 1, 9, 9, 9));
    qry_valid = 1'b1; qry_id = 3'd3; qry_clear = 1'b0;
    exp_q.push_back(mk(3, 0, 0, 255, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_count", int'(rsp_count), 1);
      chk("hold_rsp_sum",   int'(rsp_sum),   9);
      chk("hold_qry_ready", int'(qry_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_qry_ready", int'(qry_ready), 1);
    @(posedge clk); #1;
    qry_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rsp_valid", int'(rsp_valid), 1);
    chk("b2b_rsp_id",    int'(rsp_id),    3);

    // Saturation on id1.
    for (int i = 0; i < 300; i++) push(1, 255);
    @(negedge clk);
    chk("sat_flag_set", int'(sat_flag), 1);
    query(1, 1'b0, mk(1, 255, 65535, 255, 255));
    @(negedge clk);
    chk("sat_flag_sticky", int'(sat_flag), 1);

    // Reset in the middle of a push stream.
    @(posedge clk); #1;
    in_valid = 1'b1; in_id = 3'd1; in_delta = 8'd255;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_sat_flag",  int'(sat_flag),  0);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_in_ready",  int'(in_ready),  0);
    in_valid = 1'b0;
    init_check();
    query(1, 1'b0, mk(1, 0, 0, 255, 0));
    query(3, 1'b0, mk(3, 0, 0, 255, 0));

    repeat (3) @(negedge clk);
    chk("rsp_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
